// File: rtl/pwm_decoder_pkg.sv
// ---------------------------------------------------------------------------
// pwm_decoder_pkg
//   Shared definitions for the PWM decoder and its DAC counterpart:
//   FSM state encoding and the PWM period helper, so both ends of the
//   loopback agree on the period length.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package pwm_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no edge seen yet since reset
      ST_MEAS = 2'd1,   // measuring periods between rising edges
      ST_HOLD = 2'd2    // input stuck at a constant level
   } state_t;

   // PWM period in clocks for an n-bit duty code.
   function automatic int period(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/pwm_decoder_if.sv
// ---------------------------------------------------------------------------
// pwm_decoder_if
//   Result bus of the PWM decoder.
//   duty   : last recovered duty code (N bits)
//   valid  : one-cycle pulse, duty updated in the same cycle
//   locked : consecutive periods measure exactly 2^N clocks
//   err    : one-cycle pulse on a rising edge with a wrong period
//   master : driven by the decoder; slave : consumer side.
// ---------------------------------------------------------------------------
interface pwm_decoder_if #(
   parameter int N = 8
);
   logic [N-1:0] duty;
   logic         valid;
   logic         locked;
   logic         err;

   modport master (output duty, valid, locked, err);
   modport slave  (input  duty, valid, locked, err);
endinterface

// File: rtl/pwm_sync_edge.sv
// ---------------------------------------------------------------------------
// pwm_sync_edge
//   Synchronises the asynchronous PWM input and detects rising edges.
//   clk   : system clock
//   reset : synchronous, active-high
//   d     : asynchronous PWM input
//   s     : synchronised level, aligned with rise
//   rise  : registered one-cycle rising-edge pulse
//   SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic s,
   output logic rise
);
   localparam int FW = $clog2(SYNC_STAGES + 2);
   localparam logic [FW-1:0] FILL_LAST = FW'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic [FW-1:0]          fill_cnt;
   logic                   fill_done;
   logic                   s_sync;

   assign s_sync    = sync_q[SYNC_STAGES-1];
   // Edges are suppressed until the chain has filled with real samples,
   // otherwise an input already high at reset release looks like a rise.
   assign fill_done = (fill_cnt == FILL_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         rise_q   <= 1'b0;
         fill_cnt <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= s_sync;
         rise_q <= s_sync & ~prev_q & fill_done;
         if (!fill_done) fill_cnt <= fill_cnt + 1'b1;
      end
   end

   // prev_q is the synchronised level delayed to line up with rise_q.
   assign s    = prev_q;
   assign rise = rise_q;
endmodule

// File: rtl/pwm_decoder.sv
// ---------------------------------------------------------------------------
// pwm_decoder
//   Recovers the N-bit on-time of a PWM stream with a 2^N-clock period,
//   flags wrong periods and falls back to a constant-level report when
//   no edges arrive.
//   clk    : system clock
//   reset  : synchronous, active-high
//   pwm_in : PWM stream, asynchronous to clk
//   bus    : result bus (duty, valid, locked, err), all registered
// ---------------------------------------------------------------------------
module pwm_decoder
   import pwm_decoder_pkg::*;
#(
   parameter int N           = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pwm_in,
   pwm_decoder_if.master bus
);
   localparam logic [N:0] CNT_LAST = (N+1)'(period(N) - 1);

   logic         s;
   logic         rise;
   state_t       state,    state_nxt;
   logic [N:0]   per_cnt,  per_nxt;
   logic [N:0]   hi_cnt,   hi_nxt;
   logic [N-1:0] duty_q,   duty_nxt;
   logic         valid_q,  valid_nxt;
   logic         err_q,    err_nxt;
   logic         locked_q, locked_nxt;
   logic         at_last;

   pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pwm_in),
      .s     (s),
      .rise  (rise)
   );

   // Last cycle of a nominal period; a rise here means the period was 2^N.
   assign at_last = (per_cnt == CNT_LAST);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         per_cnt  <= '0;
         hi_cnt   <= '0;
         duty_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         per_cnt  <= per_nxt;
         hi_cnt   <= hi_nxt;
         duty_q   <= duty_nxt;
         valid_q  <= valid_nxt;
         err_q    <= err_nxt;
         locked_q <= locked_nxt;
      end
   end

   // Next state. A rise always wins over the timeout decision.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (rise)         state_nxt = ST_MEAS;
            else if (at_last) state_nxt = ST_HOLD;
         end
         ST_MEAS: begin
            if (!rise && at_last) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (rise) state_nxt = ST_MEAS;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Counters and output values.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      per_nxt    = per_cnt + 1'b1;
      hi_nxt     = (hi_cnt >= CNT_LAST) ? hi_cnt : hi_cnt + {{N{1'b0}}, s};
      duty_nxt   = duty_q;
      valid_nxt  = 1'b0;
      err_nxt    = 1'b0;
      locked_nxt = locked_q;

      unique case (state)
         ST_IDLE: begin
            if (rise) begin
               per_nxt = '0;
               hi_nxt  = {{N{1'b0}}, 1'b1};
            end else if (at_last) begin
               per_nxt = '0;
            end
         end
         ST_MEAS: begin
            if (rise) begin
               per_nxt = '0;
               hi_nxt  = {{N{1'b0}}, 1'b1};   // the rise cycle is high
               if (at_last) begin
                  duty_nxt   = hi_cnt[N-1:0];
                  valid_nxt  = 1'b1;
                  locked_nxt = 1'b1;
               end else begin
                  err_nxt    = 1'b1;
                  locked_nxt = 1'b0;
               end
            end else if (at_last) begin
               // Late or missing edge: treated as a constant level.
               per_nxt    = '0;
               locked_nxt = 1'b0;
            end
         end
         ST_HOLD: begin
            locked_nxt = 1'b0;
            if (rise) begin
               per_nxt = '0;
               hi_nxt  = {{N{1'b0}}, 1'b1};
            end else if (at_last) begin
               // One report per nominal period while the level is stuck.
               per_nxt   = '0;
               duty_nxt  = s ? '1 : '0;
               valid_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.duty   = duty_q;
   assign bus.valid  = valid_q;
   assign bus.err    = err_q;
   assign bus.locked = locked_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_decoder
//   Directed PWM waveforms; the expected valid/err events (kind, duty,
//   locked, cycle) are queued when each rising edge is driven and a monitor
//   compares them as the decoder emits events.
// ---------------------------------------------------------------------------
module tb_pwm_decoder;
   localparam int N   = 8;
   localparam int S   = 2;
   localparam int P   = 256;
   localparam int LAT = S + 2;   // drive cycle to event cycle

   localparam int EV_NONE  = 0;
   localparam int EV_VALID = 1;
   localparam int EV_ERR   = 2;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic pwm_in = 1'b0;
   int   cyc    = 0;

   pwm_decoder_if #(.N(N)) dif ();

   pwm_decoder #(.N(N), .SYNC_STAGES(S)) dut (
      .clk    (clk),
      .reset  (reset),
      .pwm_in (pwm_in),
      .bus    (dif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int duty;
      int locked;
      int at;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input int duty, input int locked, input int at);
      exp_t e;
      e.kind   = kind;
      e.duty   = duty;
      e.locked = locked;
      e.at     = at;
      sb.push_back(e);
   endtask

   // Monitor: one queued expectation per emitted event.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && (dif.valid || dif.err)) begin
         check("valid_err_exclusive", int'(dif.valid & dif.err), 0);
         if (sb.size() == 0) begin
            check("unexpected_event_kind", dif.err ? EV_ERR : EV_VALID, EV_NONE);
         end else begin
            e = sb.pop_front();
            check("event_kind",   dif.err ? EV_ERR : EV_VALID, e.kind);
            check("event_duty",   int'(dif.duty), e.duty);
            check("event_locked", int'(dif.locked), e.locked);
            check("event_cycle",  cyc, e.at);
         end
      end
   end

   // One PWM period starting with a (possible) rising edge; the event that
   // rising edge produces, if any, is queued.
   task automatic run_period(input int high, input int per, input int kind,
                             input int duty, input int locked);
      for (int i = 0; i < per; i++) begin
         @(posedge clk); #1;
         if (i == 0 && kind != EV_NONE) expect_ev(kind, duty, locked, cyc + LAT);
         pwm_in = (i < high);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(output int r);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      r = cyc;
      check("reset_duty",   int'(dif.duty), 0);
      check("reset_valid",  int'(dif.valid), 0);
      check("reset_locked", int'(dif.locked), 0);
      check("reset_err",    int'(dif.err), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int c;

      // 1: DAC-style 127/256, locks on the second rise.
      pwm_in = 1'b0;
      do_reset(r);
      wait_cycles(10);
      run_period(127, P, EV_NONE, 0, 0);
      run_period(127, P, EV_VALID, 127, 1);
      run_period(127, P, EV_VALID, 127, 1);
      run_period(127, P, EV_VALID, 127, 1);

      // 2: boundary codes 1 and 255.
      run_period(1,   P, EV_VALID, 127, 1);
      run_period(255, P, EV_VALID, 1,   1);
      run_period(127, P, EV_VALID, 255, 1);

      // 3: constant low into HOLD, then constant high.
      pwm_in = 1'b0;
      do_reset(r);
      expect_ev(EV_VALID, 0, 0, r + 2*P);
      expect_ev(EV_VALID, 0, 0, r + 3*P);
      expect_ev(EV_VALID, 0, 0, r + 4*P);
      while (cyc < r + 1030) @(posedge clk);
      #1;
      check("hold_locked", int'(dif.locked), 0);
      c = cyc;
      pwm_in = 1'b1;
      expect_ev(EV_VALID, P - 1, 0, c + LAT + 2*P);
      while (cyc < c + LAT + 2*P + 4) @(posedge clk);
      #1;

      // 4: period 200 gives err on every rise, then 256/64 relocks.
      pwm_in = 1'b0;
      do_reset(r);
      wait_cycles(10);
      run_period(100, 200, EV_NONE, 0, 0);
      run_period(100, 200, EV_ERR,  0, 0);
      run_period(100, 200, EV_ERR,  0, 0);
      run_period(100, 200, EV_ERR,  0, 0);
      check("err_locked", int'(dif.locked), 0);
      run_period(64, P, EV_ERR,   0,  0);
      run_period(64, P, EV_VALID, 64, 1);
      run_period(64, P, EV_VALID, 64, 1);

      // 5: reset mid-measurement with the input high.
      @(posedge clk); #1;
      expect_ev(EV_VALID, 64, 1, cyc + LAT);
      pwm_in = 1'b1;
      wait_cycles(119);
      do_reset(r);
      wait_cycles(7);
      pwm_in = 1'b0;
      wait_cycles(20);
      run_period(127, P, EV_NONE,  0,   0);
      run_period(127, P, EV_VALID, 127, 1);

      // 6: one 257-clock period times out into HOLD without err.
      run_period(127, P,     EV_VALID, 127, 1);
      run_period(127, P + 1, EV_VALID, 127, 1);
      run_period(127, P,     EV_NONE,  0,   0);
      check("jitter_locked", int'(dif.locked), 0);
      run_period(127, P, EV_VALID, 127, 1);
      run_period(127, P, EV_VALID, 127, 1);

      wait_cycles(10);
      check("pending_events", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
